// File: rtl/hpi_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hpi_pkg : shared types and constants for the HPI port arbiter       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package hpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CHIPRST = 3'd4
    } hpi_state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hpi_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hpi_rr_arb2 : two-request round-robin arbiter, one-hot grant        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hpi_rr_arb2
    import hpi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Starts as "B won last" so A wins the first tie after reset.
    logic r_last_b;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_b ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_b <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            r_last_b <= grant[PORT_B];
        end
    end

endmodule
`default_nettype wire

// File: rtl/hpi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hpi_arbiter : shares the OTG HPI port between two requesters and    |
// |               sequences timed 16-bit read/write and chip-reset cycles|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hpi_arbiter
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int RESET_CYC  = 32
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic [15:0] a_rdata,
    output logic        a_done,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic [15:0] b_rdata,
    output logic        b_done,
    input  logic        chip_rst_req,
    output logic        chip_rst_busy,
    output logic [1:0]  otg_hpi_address,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic        otg_hpi_reset_n,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in
);

    localparam int c_max_cyc = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RESET_CYC);
    localparam int c_cnt_w   = $clog2(c_max_cyc) + 1;

    localparam logic [c_cnt_w-1:0] c_setup_ld  = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_ld = c_cnt_w'(STROBE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld   = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_reset_ld  = c_cnt_w'(RESET_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    hpi_state_t           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_we;
    logic                 r_port;      // 0 = A, 1 = B
    logic                 r_rst_pend;

    logic [1:0]  w_grant;
    logic        w_advance;
    logic        w_pick_b;
    logic        w_we;
    logic [1:0]  w_addr;
    logic [15:0] w_wdata;

    assign w_advance = (r_state == ST_IDLE) && !r_rst_pend;
    assign w_pick_b  = w_grant[PORT_B];
    assign w_we      = w_pick_b ? b_we    : a_we;
    assign w_addr    = w_pick_b ? b_addr  : a_addr;
    assign w_wdata   = w_pick_b ? b_wdata : a_wdata;

    hpi_rr_arb2 u_arb (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .req     ({b_req, a_req}),
        .advance (w_advance),
        .grant   (w_grant)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_we             <= 1'b0;
            r_port           <= 1'b0;
            r_rst_pend       <= 1'b0;
            otg_hpi_address  <= 2'd0;
            otg_hpi_cs_n     <= 1'b1;
            otg_hpi_r_n      <= 1'b1;
            otg_hpi_w_n      <= 1'b1;
            otg_hpi_reset_n  <= 1'b0;
            otg_hpi_data_out <= 16'd0;
            otg_hpi_data_oe  <= 1'b0;
            a_done           <= 1'b0;
            b_done           <= 1'b0;
            a_rdata          <= 16'd0;
            b_rdata          <= 16'd0;
            chip_rst_busy    <= 1'b0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;

            // A reset request is remembered in any state except while one is running.
            if (chip_rst_req && (r_state != ST_CHIPRST)) begin
                r_rst_pend    <= 1'b1;
                chip_rst_busy <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    otg_hpi_reset_n <= 1'b1;
                    if (r_rst_pend) begin
                        r_state         <= ST_CHIPRST;
                        r_cnt           <= c_reset_ld;
                        r_rst_pend      <= 1'b0;
                        otg_hpi_reset_n <= 1'b0;
                    end else if (w_grant != 2'b00) begin
                        r_state         <= ST_SETUP;
                        r_cnt           <= c_setup_ld;
                        r_port          <= w_pick_b;
                        r_we            <= w_we;
                        otg_hpi_address <= w_addr;
                        otg_hpi_cs_n    <= 1'b0;
                        if (w_we) begin
                            otg_hpi_data_out <= w_wdata;
                            otg_hpi_data_oe  <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_STROBE;
                        r_cnt       <= c_strobe_ld;
                        otg_hpi_r_n <= r_we;
                        otg_hpi_w_n <= !r_we;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end

                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_HOLD;
                        r_cnt       <= c_hold_ld;
                        otg_hpi_r_n <= 1'b1;
                        otg_hpi_w_n <= 1'b1;
                        if (!r_we) begin
                            if (r_port) b_rdata <= otg_hpi_data_in;
                            else        a_rdata <= otg_hpi_data_in;
                        end
                        if (HOLD_CYC == 1) begin
                            if (r_port) b_done <= 1'b1;
                            else        a_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end

                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state         <= ST_IDLE;
                        otg_hpi_cs_n    <= 1'b1;
                        otg_hpi_data_oe <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                        // done must land on the final HOLD cycle
                        if (r_cnt == c_one) begin
                            if (r_port) b_done <= 1'b1;
                            else        a_done <= 1'b1;
                        end
                    end
                end

                ST_CHIPRST: begin
                    if (r_cnt == '0) begin
                        r_state         <= ST_IDLE;
                        otg_hpi_reset_n <= 1'b1;
                        chip_rst_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
